// File: rtl/uart_tx_ext.sv
// UART transmitter with a small transmit FIFO, per-frame configuration
// (length, parity, stop bits, baud divisor) latched when a word is popped.
module uart_tx_ext #(
  parameter int DATA_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [3:0]                    data_len,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          stop2,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLING);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  // Frame configuration captured at pop
  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_len;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_parity;
  logic [DIV_WIDTH-1:0]  r_div_lat;

  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [TW-1:0]         r_tick;
  logic [3:0]            r_bit;
  logic                  r_tx;

  logic                  w_baud_tick;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_tx_next;
  logic [3:0]            w_len_eff;
  logic [DATA_WIDTH-1:0] w_data_masked;
  logic                  w_parity_calc;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = tx_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  assign tx_ready   = !w_full;
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != IDLE);
  assign tx_done    = w_frame_end;

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Out-of-range lengths fall back to the full word; unused bits are zeroed
  always_comb begin
    w_len_eff = data_len;
    if (data_len < 4'd5 || data_len > 4'(DATA_WIDTH)) w_len_eff = 4'(DATA_WIDTH);
    w_data_masked = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_data_masked[i] = w_head[i] & (i < {28'b0, w_len_eff});
    end
    w_parity_calc = (^w_data_masked) ^ parity_type;
  end

  assign w_baud_tick = (r_div_cnt == r_div_lat);
  assign w_bit_end   = w_baud_tick && (r_tick == TW'(OVERSAMPLING - 1));

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = START;
        end
      end
      START: if (w_bit_end) w_next = DATA;
      DATA: begin
        if (w_bit_end && r_bit == r_len - 4'd1) w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: if (w_bit_end) w_next = STOP;
      STOP: begin
        if (w_bit_end && r_bit == {3'b000, r_stop2}) begin
          w_frame_end = 1'b1;
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = START;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // tx is registered from the next state so it changes on the same edge as the FSM
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = (r_state == DATA && w_bit_end) ? r_shift[1] : r_shift[0];
      PARITY:  w_tx_next = r_parity;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_len     <= '0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_parity  <= 1'b0;
      r_div_lat <= '0;
      r_div_cnt <= '0;
      r_tick    <= '0;
      r_bit     <= '0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_next;
      if (w_pop) begin
        r_shift   <= w_data_masked;
        r_len     <= w_len_eff;
        r_par_en  <= parity_en;
        r_stop2   <= stop2;
        r_parity  <= w_parity_calc;
        r_div_lat <= baud_div;
      end else if (r_state == DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
      if (w_pop || r_state == IDLE) begin
        r_div_cnt <= '0;
        r_tick    <= '0;
        r_bit     <= '0;
      end else begin
        r_div_cnt <= w_baud_tick ? '0 : r_div_cnt + 1'b1;
        if (w_baud_tick) r_tick <= r_tick + 1'b1;
        if (w_bit_end) r_bit <= (w_next != r_state) ? '0 : r_bit + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed self-checking bench for uart_tx_ext: frame shapes, parity, FIFO
// fill/drop, baud timing and mid-frame reset.
module tb_uart_tx_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  data_len;
  logic        parity_en;
  logic        parity_type;
  logic        stop2;
  logic [15:0] baud_div;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic wave  [0:1023];
  logic busyw [0:1023];
  int   done_pos [0:7];
  int   n_done;

  uart_tx_ext #(
    .DATA_WIDTH(8), .OVERSAMPLING(16), .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_len(data_len), .parity_en(parity_en),
    .parity_type(parity_type), .stop2(stop2), .baud_div(baud_div),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a start bit, then records tx/busy/done per cycle; n=0 is the first low sample.
  task automatic capture(input int ncyc, output bit found);
    found = 1'b0;
    for (int w = 0; w < 400; w++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_done = 0;
    for (int i = 0; i < 8; i++) done_pos[i] = -1;
    if (found) begin
      for (int n = 0; n < ncyc; n++) begin
        if (n > 0) begin @(posedge clk); #1; end
        wave[n]  = tx;
        busyw[n] = tx_busy;
        if (tx_done === 1'b1) begin
          if (n_done < 8) done_pos[n_done] = n;
          n_done++;
        end
      end
    end
  endtask

  function automatic int first_bad(input int from, input int len, input logic val);
    for (int i = from; i < from + len && i < 1024; i++) begin
      if (wave[i] !== val) return i;
    end
    return -1;
  endfunction

  task automatic wait_idle(output bit ok);
    int k = 0;
    while ((tx_busy !== 1'b0 || fifo_count !== 3'd0) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (k < 2000);
  endtask

  task automatic push1(input logic [7:0] d);
    data_in = d; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_basic;
    bit found, ok;
    int fb;
    logic [9:0] e;
    data_len = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd0;
    push1(8'hA5);
    capture(200, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL a5_start: no start bit, got %b expected 1", found); end
    e = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      fb = first_bad(b * 16, 16, e[b]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL a5_bit%0d: tx=%b at cycle %0d expected %b", b, wave[fb], fb, e[b]); end
    end
    fb = first_bad(160, 40, 1'b1);
    checks++; if (fb !== -1) begin errors++; $display("FAIL a5_idle: tx=%b at cycle %0d expected 1", wave[fb], fb); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL a5_done_cnt: got %0d expected 1", n_done); end
    checks++; if (done_pos[0] !== 159) begin errors++; $display("FAIL a5_done_pos: got %0d expected 159", done_pos[0]); end
    checks++; if (busyw[159] !== 1'b1) begin errors++; $display("FAIL a5_busy_last: got %b expected 1", busyw[159]); end
    checks++; if (busyw[160] !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", busyw[160]); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL a5_idle_wait: got %b expected 1", ok); end
  endtask

  task automatic test_even_parity;
    bit found, ok;
    int fb;
    logic [10:0] e;
    data_len = 4'd7; parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b1; baud_div = 16'd0;
    push1(8'h55);
    capture(200, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL even_start: no start bit, got %b expected 1", found); end
    e = {2'b11, 1'b0, 7'h55, 1'b0};
    for (int b = 0; b < 11; b++) begin
      fb = first_bad(b * 16, 16, e[b]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL even_bit%0d: tx=%b at cycle %0d expected %b", b, wave[fb], fb, e[b]); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL even_done_cnt: got %0d expected 1", n_done); end
    checks++; if (done_pos[0] !== 175) begin errors++; $display("FAIL even_done_pos: got %0d expected 175", done_pos[0]); end
    checks++; if (busyw[176] !== 1'b0) begin errors++; $display("FAIL even_busy_after: got %b expected 0", busyw[176]); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL even_idle_wait: got %b expected 1", ok); end
  endtask

  task automatic test_odd_parity;
    bit found, ok;
    int fb;
    logic [21:0] e;
    data_len = 4'd8; parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b0; baud_div = 16'd0;
    data_in = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    capture(380, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL odd_start: no start bit, got %b expected 1", found); end
    e = {1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    for (int b = 0; b < 22; b++) begin
      fb = first_bad(b * 16, 16, e[b]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL odd_bit%0d: tx=%b at cycle %0d expected %b", b, wave[fb], fb, e[b]); end
    end
    fb = first_bad(352, 28, 1'b1);
    checks++; if (fb !== -1) begin errors++; $display("FAIL odd_idle: tx=%b at cycle %0d expected 1", wave[fb], fb); end
    checks++; if (n_done !== 2) begin errors++; $display("FAIL odd_done_cnt: got %0d expected 2", n_done); end
    checks++; if (done_pos[1] !== 351) begin errors++; $display("FAIL odd_done_pos: got %0d expected 351", done_pos[1]); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL odd_idle_wait: got %b expected 1", ok); end
  endtask

  task automatic test_fifo_full;
    bit found, ok;
    int fb;
    logic [6:0] e;
    logic [4:0] w5;
    data_len = 4'd5; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          data_in = 8'(k); tx_valid = 1'b1;
          checks++;
          if (tx_ready !== (k < 6)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", k, tx_ready, (k < 6)); end
          @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
      end
      begin
        capture(700, found);
      end
    join
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL full_start: no start bit, got %b expected 1", found); end
    for (int f = 0; f < 5; f++) begin
      w5 = 5'(f + 1);
      e = {1'b1, w5, 1'b0};
      for (int b = 0; b < 7; b++) begin
        fb = first_bad(f * 112 + b * 16, 16, e[b]);
        checks++; if (fb !== -1) begin errors++; $display("FAIL full_f%0d_bit%0d: tx=%b at cycle %0d expected %b", f + 1, b, wave[fb], fb, e[b]); end
      end
      checks++; if (done_pos[f] !== f * 112 + 111) begin errors++; $display("FAIL full_done%0d: got %0d expected %0d", f + 1, done_pos[f], f * 112 + 111); end
    end
    fb = first_bad(560, 140, 1'b1);
    checks++; if (fb !== -1) begin errors++; $display("FAIL full_word6_dropped: tx=%b at cycle %0d expected 1", wave[fb], fb); end
    checks++; if (n_done !== 5) begin errors++; $display("FAIL full_done_cnt: got %0d expected 5", n_done); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_idle_wait: got %b expected 1", ok); end
  endtask

  task automatic test_baud;
    bit found, ok;
    int fb;
    logic [19:0] e;
    data_len = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd2;
    fork
      begin
        data_in = 8'h3C; tx_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hC3;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        baud_div = 16'd0;
      end
      begin
        capture(700, found);
      end
    join
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL baud_start: no start bit, got %b expected 1", found); end
    e = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int b = 0; b < 10; b++) begin
      fb = first_bad(b * 48, 48, e[b]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL baud_f1_bit%0d: tx=%b at cycle %0d expected %b", b, wave[fb], fb, e[b]); end
    end
    for (int b = 0; b < 10; b++) begin
      fb = first_bad(480 + b * 16, 16, e[b + 10]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL baud_f2_bit%0d: tx=%b at cycle %0d expected %b", b, wave[fb], fb, e[b + 10]); end
    end
    checks++; if (done_pos[0] !== 479) begin errors++; $display("FAIL baud_done1: got %0d expected 479", done_pos[0]); end
    checks++; if (done_pos[1] !== 639) begin errors++; $display("FAIL baud_done2: got %0d expected 639", done_pos[1]); end
    checks++; if (n_done !== 2) begin errors++; $display("FAIL baud_done_cnt: got %0d expected 2", n_done); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL baud_idle_wait: got %b expected 1", ok); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lows  = 0;
    data_len = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = 16'd0;
    data_in = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h11;
    @(posedge clk); #1;
    data_in = 8'h22;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", fifo_count); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b expected 0", tx); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", tx_busy); end
    reset = 1'b0; data_in = 8'h33; tx_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", tx_done); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", tx_ready); end
    reset = 1'b1; tx_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1) dones++;
      if (tx !== 1'b1) lows++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL rst_line_idle: got %0d non-idle cycles expected 0", lows); end
  endtask

  initial begin
    reset = 1'b0; data_in = '0; tx_valid = 1'b0; data_len = 4'd8;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; baud_div = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_even_parity;
    test_odd_parity;
    test_fifo_full;
    test_baud;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
